// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//  - funct3 encodings for access size/signedness (inst[14:12])
//  - LSU FSM state type
//  - f3_size: maps funct3 to an access size code (0=byte, 1=half, 2=word)
package pipeline_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } lsu_state_e;

    // Size is carried in funct3[1:0]; any encoding that is not byte or half
    // (including the unused ones) is treated as a full word.
    function automatic logic [1:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            F3_B[1:0]: return 2'd0;
            F3_H[1:0]: return 2'd1;
            default:   return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//  i_funct3   in  3      access size/signedness
//  i_off      in  2      byte offset within the word (addr[1:0])
//  i_wsrc     in  Width  store source data (rs2)
//  i_rdata    in  Width  raw read word from memory
//  o_be       out Width/8 byte enables
//  o_wdata    out Width  lane-replicated store data
//  o_ldata    out Width  extracted and extended load value
//  o_misalign out 1      access not naturally aligned for its size
module lsu_align
    import pipeline_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_off,
    input  logic [Width-1:0]   i_wsrc,
    input  logic [Width-1:0]   i_rdata,
    output logic [Width/8-1:0] o_be,
    output logic [Width-1:0]   o_wdata,
    output logic [Width-1:0]   o_ldata,
    output logic               o_misalign
);

    logic [Width-1:0] w_r;
    logic             w_uns;

    // Shift the addressed byte lane down to bit 0 before extending.
    assign w_r   = i_rdata >> {i_off, 3'b000};
    assign w_uns = i_funct3[2];

    always_comb begin
        o_be       = '0;
        o_wdata    = '0;
        o_ldata    = '0;
        o_misalign = 1'b0;
        case (f3_size(i_funct3))
            2'd0: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_wsrc[7:0]}};
                o_ldata = {{24{w_r[7] & ~w_uns}}, w_r[7:0]};
            end
            2'd1: begin
                o_be       = 4'b0011 << i_off;
                o_wdata    = {2{i_wsrc[15:0]}};
                o_ldata    = {{16{w_r[15] & ~w_uns}}, w_r[15:0]};
                o_misalign = i_off[0];
            end
            default: begin
                o_be       = 4'b1111;
                o_wdata    = i_wsrc;
                o_ldata    = w_r;
                o_misalign = (i_off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the 5-stage RV32I pipeline.
// Issues one req/ack data-memory transaction per MEM-stage load or store,
// stalls IF..MEM while memory has not acknowledged, and formats load data
// for the MEM/WB register.
//  clk_i, rst_ni            clock, async active-low reset
//  MemRen_MEM, MemWen_MEM   load / store in MEM (store wins if both)
//  funct3_MEM, alu_MEM      access size/sign, byte address
//  rs2_MEM                  store data
//  pipe_stall_i             external hazard stall holding MEM
//  dmem_*                   memory request port (ack same-cycle rdata)
//  dataR                    formatted load result (0 for stores/idle)
//  stall_o                  hold IF..MEM while waiting for ack
//  misalign_o               misaligned access, not issued
module mem_stage_lsu
    import pipeline_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               MemRen_MEM,
    input  logic               MemWen_MEM,
    input  logic [2:0]         funct3_MEM,
    input  logic [Width-1:0]   alu_MEM,
    input  logic [Width-1:0]   rs2_MEM,
    input  logic               pipe_stall_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [Width-1:0]   dmem_addr_o,
    output logic [Width/8-1:0] dmem_be_o,
    output logic [Width-1:0]   dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [Width-1:0]   dmem_rdata_i,
    output logic [Width-1:0]   dataR,
    output logic               stall_o,
    output logic               misalign_o
);

    lsu_state_e r_state, w_next;

    logic [Width-1:0]   r_addr, r_wdata, r_rdata;
    logic [Width/8-1:0] r_be;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic               r_we;

    logic               w_in_wait, w_access, w_load, w_latch, w_cap;
    logic [2:0]         w_f3;
    logic [1:0]         w_off;
    logic [Width/8-1:0] w_be;
    logic [Width-1:0]   w_wdata, w_ldata, w_fmt;
    logic               w_mis;

    assign w_in_wait = (r_state == WAIT);
    assign w_access  = MemRen_MEM | MemWen_MEM;

    // While waiting, the MEM inputs may already belong to something else, so
    // formatting of the returning word uses the latched access descriptor.
    assign w_f3   = w_in_wait ? r_funct3 : funct3_MEM;
    assign w_off  = w_in_wait ? r_off    : alu_MEM[1:0];
    assign w_load = w_in_wait ? ~r_we    : ~MemWen_MEM;
    assign w_fmt  = w_load ? w_ldata : '0;

    lsu_align #(.Width(Width)) u_align (
        .i_funct3   (w_f3),
        .i_off      (w_off),
        .i_wsrc     (rs2_MEM),
        .i_rdata    (dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_mis)
    );

    always_comb begin
        w_next       = r_state;
        w_latch      = 1'b0;
        w_cap        = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = '0;
        dmem_wdata_o = '0;
        dataR        = '0;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_mis) begin
                        misalign_o = 1'b1;
                    end else begin
                        dmem_req_o   = 1'b1;
                        dmem_we_o    = MemWen_MEM;
                        dmem_addr_o  = {alu_MEM[Width-1:2], 2'b00};
                        dmem_be_o    = w_be;
                        dmem_wdata_o = MemWen_MEM ? w_wdata : '0;
                        if (dmem_ack_i) begin
                            dataR = w_fmt;
                            w_cap = 1'b1;
                            if (pipe_stall_i) w_next = HOLD;
                        end else begin
                            stall_o = 1'b1;
                            w_latch = 1'b1;
                            w_next  = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = r_we;
                dmem_addr_o  = r_addr;
                dmem_be_o    = r_be;
                dmem_wdata_o = r_wdata;
                if (dmem_ack_i) begin
                    dataR  = w_fmt;
                    w_cap  = 1'b1;
                    w_next = pipe_stall_i ? HOLD : IDLE;
                end else begin
                    stall_o = 1'b1;
                end
            end
            HOLD: begin
                // Access already completed; replay the result, never reissue.
                dataR = r_rdata;
                if (!pipe_stall_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // In reset the state is already IDLE, but IDLE decodes the live MEM
        // inputs combinationally; force everything quiet until reset lifts.
        if (!rst_ni) begin
            w_next       = IDLE;
            w_latch      = 1'b0;
            w_cap        = 1'b0;
            dmem_req_o   = 1'b0;
            dmem_we_o    = 1'b0;
            dmem_addr_o  = '0;
            dmem_be_o    = '0;
            dmem_wdata_o = '0;
            dataR        = '0;
            stall_o      = 1'b0;
            misalign_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_be     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_we     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_addr   <= {alu_MEM[Width-1:2], 2'b00};
                r_wdata  <= MemWen_MEM ? w_wdata : '0;
                r_be     <= w_be;
                r_funct3 <= funct3_MEM;
                r_off    <= alu_MEM[1:0];
                r_we     <= MemWen_MEM;
            end
            if (w_cap) r_rdata <= w_fmt;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        MemRen_MEM = 1'b0, MemWen_MEM = 1'b0;
    logic [2:0]  funct3_MEM = '0;
    logic [31:0] alu_MEM = '0, rs2_MEM = '0;
    logic        pipe_stall_i = 1'b0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic [31:0] dataR;
    logic        stall_o, misalign_o;

    int n_chk = 0;
    int n_pass = 0;

    wire [7:0] ctl = {dmem_req_o, dmem_we_o, stall_o, misalign_o, dmem_be_o};

    mem_stage_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .MemRen_MEM(MemRen_MEM), .MemWen_MEM(MemWen_MEM),
        .funct3_MEM(funct3_MEM), .alu_MEM(alu_MEM), .rs2_MEM(rs2_MEM),
        .pipe_stall_i(pipe_stall_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .dataR(dataR),
        .stall_o(stall_o), .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (m_size(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint v, span;
        int s;
        s = m_size(f3);
        v = longint'(rd >> (8 * int'(a[1:0])));
        if (s < 4) begin
            span = longint'(1) << (8 * s);
            v = v % span;
            if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
        end
        return 32'(v);
    endfunction

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in();
        MemRen_MEM = 0; MemWen_MEM = 0; funct3_MEM = 0; alu_MEM = 0; rs2_MEM = 0;
        pipe_stall_i = 0; dmem_ack_i = 0; dmem_rdata_i = 0;
    endtask

    task automatic scramble();
        MemRen_MEM = 1'($urandom); MemWen_MEM = 1'($urandom); funct3_MEM = 3'($urandom);
        alu_MEM = $urandom; rs2_MEM = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_in();
        rst_ni = 0;
        MemRen_MEM = 1; funct3_MEM = 3'b010; alu_MEM = 32'h40; dmem_ack_i = 1;
        dmem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00 || dataR !== 0) $display("FAIL reset_out ctl=%h dataR=%h want 00/0", ctl, dataR); else n_pass++;
        tick(); rst_ni = 1; idle_in(); dmem_ack_i = 1; dmem_rdata_i = $urandom;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00 || {dmem_addr_o, dmem_wdata_o, dataR} !== 96'h0)
            $display("FAIL idle_ack ctl=%h addr=%h wd=%h dataR=%h want all 0", ctl, dmem_addr_o, dmem_wdata_o, dataR); else n_pass++;
    endtask

    task automatic test_lw_zero_wait();
        tick(); idle_in();
        MemRen_MEM = 1; funct3_MEM = 3'b010; alu_MEM = 32'h100; dmem_ack_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'b1000_1111 || dmem_addr_o !== 32'h100) $display("FAIL lw_bus ctl=%h addr=%h want 8f/100", ctl, dmem_addr_o); else n_pass++;
        n_chk++; if (dataR !== 32'hDEAD_BEEF) $display("FAIL lw_data got=%h want deadbeef", dataR); else n_pass++;
        tick(); idle_in();
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00 || dataR !== 0) $display("FAIL lw_one_req ctl=%h dataR=%h want 0", ctl, dataR); else n_pass++;
    endtask

    task automatic test_lb_lbu();
        logic [2:0] f3s [2];
        logic [31:0] exps [2];
        f3s[0] = 3'b000; f3s[1] = 3'b100; exps[0] = 32'hFFFF_FF80; exps[1] = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            tick(); idle_in();
            MemRen_MEM = 1; funct3_MEM = f3s[i]; alu_MEM = 32'h103; dmem_ack_i = 1; dmem_rdata_i = 32'h80FF_1234;
            @(negedge clk_i);
            n_chk++; if (ctl !== 8'b1000_1000 || dmem_addr_o !== 32'h100) $display("FAIL lb_bus%0d ctl=%h addr=%h want 88/100", i, ctl, dmem_addr_o); else n_pass++;
            n_chk++; if (dataR !== exps[i]) $display("FAIL lb_data%0d got=%h want %h", i, dataR, exps[i]); else n_pass++;
        end
    endtask

    task automatic test_sh_wait();
        tick(); idle_in();
        MemWen_MEM = 1; funct3_MEM = 3'b001; alu_MEM = 32'h202; rs2_MEM = 32'h0000_ABCD;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin tick(); scramble(); dmem_ack_i = (k == 3); dmem_rdata_i = $urandom; end
            @(negedge clk_i);
            n_chk++; if (ctl !== {3'b110 | {2'b00, k < 3}, 1'b0, 4'b1100})
                $display("FAIL sh_ctl%0d ctl=%h want %h", k, ctl, {3'b110 | {2'b00, k < 3}, 1'b0, 4'b1100}); else n_pass++;
            n_chk++; if (dmem_addr_o !== 32'h200 || dmem_wdata_o !== 32'hABCD_ABCD || dataR !== 0)
                $display("FAIL sh_bus%0d addr=%h wd=%h dataR=%h want 200/abcdabcd/0", k, dmem_addr_o, dmem_wdata_o, dataR); else n_pass++;
        end
        tick(); idle_in();
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00) $display("FAIL sh_after ctl=%h want 00", ctl); else n_pass++;
    endtask

    task automatic test_misalign();
        tick(); idle_in();
        MemRen_MEM = 1; funct3_MEM = 3'b010; alu_MEM = 32'h101; dmem_ack_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'b0001_0000 || dataR !== 0) $display("FAIL misalign ctl=%h dataR=%h want 10/0", ctl, dataR); else n_pass++;
    endtask

    task automatic test_hold();
        tick(); idle_in();
        MemRen_MEM = 1; funct3_MEM = 3'b001; alu_MEM = 32'h002; dmem_ack_i = 1;
        dmem_rdata_i = 32'h8001_5A5A; pipe_stall_i = 1;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'b1000_1100 || dataR !== 32'hFFFF_8001) $display("FAIL hold_issue ctl=%h dataR=%h want 8c/ffff8001", ctl, dataR); else n_pass++;
        for (int j = 0; j < 2; j++) begin
            tick(); dmem_ack_i = 1'(j); dmem_rdata_i = $urandom; pipe_stall_i = (j == 0);
            @(negedge clk_i);
            n_chk++; if (ctl !== 8'h00 || dataR !== 32'hFFFF_8001) $display("FAIL hold%0d ctl=%h dataR=%h want 00/ffff8001", j, ctl, dataR); else n_pass++;
        end
        tick(); idle_in();
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00 || dataR !== 0) $display("FAIL hold_exit ctl=%h dataR=%h want 0", ctl, dataR); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        tick(); idle_in();
        MemRen_MEM = 1; funct3_MEM = 3'b010; alu_MEM = 32'h300;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'b1010_1111) $display("FAIL rw_issue ctl=%h want af", ctl); else n_pass++;
        tick();
        #2 rst_ni = 0;
        #1;
        n_chk++; if (dmem_req_o !== 0 || stall_o !== 0) $display("FAIL rw_drop req=%b stall=%b want 0", dmem_req_o, stall_o); else n_pass++;
        @(negedge clk_i); rst_ni = 1; idle_in();
        tick(); dmem_ack_i = 1; dmem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        n_chk++; if (ctl !== 8'h00 || dataR !== 0) $display("FAIL rw_late_ack ctl=%h dataR=%h want 0", ctl, dataR); else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic we; logic [2:0] f3; logic [31:0] a, d, rd, expd, ewd; logic [3:0] ebe;
            int n, h;
            we = 1'($urandom); f3 = 3'($urandom); a = $urandom; d = $urandom; rd = $urandom;
            n = $urandom_range(0, 3); h = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'(int'(a[1:0]) - int'(a[1:0]) % m_size(f3));
            expd = we ? 32'h0 : m_load(f3, a, rd);
            ebe  = m_be(f3, a);
            ewd  = we ? m_wdata(f3, d) : 32'h0;
            tick(); idle_in();
            MemWen_MEM = we; MemRen_MEM = ~we | 1'($urandom); funct3_MEM = f3; alu_MEM = a; rs2_MEM = d;
            if (m_mis(f3, a)) begin
                @(negedge clk_i);
                n_chk++; if (ctl !== 8'b0001_0000 || dataR !== 0) $display("FAIL rnd_mis%0d ctl=%h dataR=%h want 10/0", t, ctl, dataR); else n_pass++;
                continue;
            end
            for (int k = 0; k <= n; k++) begin
                if (k > 0) begin tick(); scramble(); end
                dmem_ack_i = (k == n); dmem_rdata_i = (k == n) ? rd : $urandom;
                pipe_stall_i = (k == n) && (h > 0);
                @(negedge clk_i);
                n_chk++; if (ctl !== {1'b1, we, k < n, 1'b0, ebe})
                    $display("FAIL rnd_ctl%0d.%0d ctl=%h want %h", t, k, ctl, {1'b1, we, k < n, 1'b0, ebe}); else n_pass++;
                n_chk++; if (dmem_addr_o !== {a[31:2], 2'b00} || dmem_wdata_o !== ewd)
                    $display("FAIL rnd_bus%0d.%0d addr=%h wd=%h want %h/%h", t, k, dmem_addr_o, dmem_wdata_o, {a[31:2], 2'b00}, ewd); else n_pass++;
                if (k == n) begin
                    n_chk++; if (dataR !== expd) $display("FAIL rnd_data%0d f3=%0d a=%h got=%h want %h", t, f3, a, dataR, expd); else n_pass++;
                end
            end
            for (int j = 0; j < h; j++) begin
                tick(); scramble(); dmem_ack_i = 1'($urandom); dmem_rdata_i = $urandom;
                pipe_stall_i = (j < h - 1);
                @(negedge clk_i);
                n_chk++; if (ctl !== 8'h00 || dataR !== expd) $display("FAIL rnd_hold%0d.%0d ctl=%h dataR=%h want 00/%h", t, j, ctl, dataR, expd); else n_pass++;
            end
            tick(); idle_in();
            @(negedge clk_i);
            n_chk++; if (ctl !== 8'h00 || dataR !== 0) $display("FAIL rnd_idle%0d ctl=%h dataR=%h want 0", t, ctl, dataR); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_lb_lbu();
        test_sh_wait();
        test_misalign();
        test_hold();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Bound the run in case something stalls the sequence.
    initial begin
        #200000;
        $display("FAIL timeout reached after %0d/%0d checks", n_pass, n_chk);
        $fatal(1);
    end

endmodule
